// File: rtl/axis_tx_pkg.sv
// Shared types and default sizes for the AXI-Stream transmit framer.
package axis_tx_pkg;

    localparam int unsigned DEF_DATA_WIDTH     = 8;
    localparam int unsigned DEF_NUM_COUNT_BITS = 16;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

endpackage

// File: rtl/axis_out_reg.sv
// One-deep valid/ready pipeline register; accepts a new beat whenever it is empty or draining.
module axis_out_reg #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             in_ready_c_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign in_ready_c_o = !valid_q || out_ready_i;

    // Payload only moves on a load, so a stalled beat stays bit-stable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready_c_o) begin
            valid_q <= in_valid_i;
            if (in_valid_i) begin
                data_q <= in_data_i;
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

endmodule

// File: rtl/axis_msg_framer.sv
// Transmit-side framer: takes a length command, forwards that many payload beats and
// marks the final one with m_tlast.
module axis_msg_framer
    import axis_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned NUM_COUNT_BITS = DEF_NUM_COUNT_BITS
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [NUM_COUNT_BITS-1:0] cmd_len,
    input  logic [DATA_WIDTH-1:0]     s_tdata,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    output logic [DATA_WIDTH-1:0]     m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      m_tlast,
    output logic                      busy,
    output logic                      tx_done,
    output logic                      zero_len
);

    state_t                    state_q, state_d;
    logic [NUM_COUNT_BITS-1:0] remaining_q, remaining_d;
    logic                      tx_done_q;
    logic                      zero_len_q;
    logic                      out_ready_c;
    logic                      in_valid_c;
    logic                      in_hs_c;
    logic                      last_beat_c;
    logic [DATA_WIDTH:0]       out_payload;

    assign in_hs_c     = s_tvalid && s_tready;
    assign last_beat_c = (remaining_q == NUM_COUNT_BITS'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
        end
    end

    // remaining is at least 1 whenever STREAM accepts a beat, so it cannot wrap.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && (cmd_len != '0)) begin
                    state_d     = STREAM;
                    remaining_d = cmd_len;
                end
            end
            STREAM: begin
                if (in_hs_c) begin
                    remaining_d = remaining_q - NUM_COUNT_BITS'(1);
                    if (last_beat_c) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        s_tready   = 1'b0;
        in_valid_c = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
            end
            STREAM: begin
                s_tready   = out_ready_c;
                in_valid_c = s_tvalid;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

    axis_out_reg #(
        .WIDTH(DATA_WIDTH + 1)
    ) u_out_reg (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_c),
        .in_data_i   ({last_beat_c, s_tdata}),
        .in_ready_c_o(out_ready_c),
        .out_valid_o (m_tvalid),
        .out_data_o  (out_payload),
        .out_ready_i (m_tready)
    );

    assign m_tlast = out_payload[DATA_WIDTH];
    assign m_tdata = out_payload[DATA_WIDTH-1:0];

    // Single-cycle status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_done_q  <= 1'b0;
            zero_len_q <= 1'b0;
        end else begin
            tx_done_q  <= m_tvalid && m_tready && m_tlast;
            zero_len_q <= (state_q == IDLE) && cmd_valid && (cmd_len == '0);
        end
    end

    assign tx_done  = tx_done_q;
    assign zero_len = zero_len_q;
    assign busy     = (state_q == STREAM) || m_tvalid;

endmodule

// File: doc/axis_msg_framer.md
Name: axis_msg_framer

Overview:
- AXI-Stream transmit-side framer, the counterpart of the receive-side message-length counter.
- Accepts a per-message length command, then forwards exactly that many payload beats from an upstream data stream to an AXI-Stream master port.
- Asserts m_tlast on the final beat of each message.
- Sits between the payload source and the outbound AXI-Stream link; registered output, full throughput within a message.

Parameters:
- DATA_WIDTH, 8: width of s_tdata / m_tdata.
- NUM_COUNT_BITS, 16: width of cmd_len and the internal beat counter; maximum message length is 2^NUM_COUNT_BITS-1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  length command valid.
- cmd_ready  out  1  framer can accept a command.
- cmd_len  in  NUM_COUNT_BITS  beats in the next message.
- s_tdata  in  DATA_WIDTH  payload in.
- s_tvalid  in  1  payload valid.
- s_tready  out  1  payload accepted this cycle when s_tvalid is also high.
- m_tdata  out  DATA_WIDTH  payload out.
- m_tvalid  out  1  output beat valid.
- m_tready  in  1  downstream ready.
- m_tlast  out  1  marks the final beat of the message.
- busy  out  1  state is STREAM or the output register holds a beat.
- tx_done  out  1  one-cycle pulse on the m_tlast handshake.
- zero_len  out  1  one-cycle pulse when a cmd_len==0 command is accepted.

Behaviour:
- Reset values: m_tvalid=0, m_tlast=0, m_tdata=0, tx_done=0, zero_len=0, state=IDLE, remaining=0. Resulting outputs: cmd_ready=1, s_tready=0, busy=0.
- FSM, typedef state_t, two states:
  - IDLE: cmd_ready=1, s_tready=0.
    - cmd_valid with cmd_len!=0: load remaining=cmd_len, go to STREAM.
    - cmd_valid with cmd_len==0: stay in IDLE, pulse zero_len next cycle, emit no beats.
  - STREAM: cmd_ready=0; s_tready = !m_tvalid || m_tready.
    - On each input handshake: load the output register with s_tdata, set m_tvalid=1, set m_tlast=(remaining==1), decrement remaining.
    - Input handshake with remaining==1: go to IDLE.
- Output register:
  - Updated only when empty or draining (!m_tvalid || m_tready).
  - While m_tvalid && !m_tready, m_tdata and m_tlast hold stable.
  - m_tvalid never drops without a handshake.
  - Output handshake with no new input beat: m_tvalid=0 next cycle.
- Latency and throughput:
  - Input beat accepted in cycle N is presented on m_* in cycle N+1.
  - Within a message: one beat per cycle when s_tvalid and m_tready stay high.
  - Between messages: at least one idle cycle for command acceptance.
  - A new command may be accepted while the previous last beat is still waiting in the output register.
- remaining is NUM_COUNT_BITS wide and never wraps; no decrement in IDLE.
- tx_done is registered: high the cycle after m_tvalid && m_tready && m_tlast.
- busy = (state==STREAM) || m_tvalid.
- Simultaneous events:
  - Output drain and new input in the same cycle: register reloads, m_tvalid stays 1.
  - cmd_valid while in STREAM: ignored, since cmd_ready=0.
- Reset mid-message: all state cleared immediately and the partial message is dropped with no m_tlast. The upstream source is responsible for re-synchronising.

Decomposition:
- Package axis_tx_pkg holds:
  - typedef enum logic {IDLE, STREAM} state_t
  - default DATA_WIDTH and NUM_COUNT_BITS localparams.
- One sub-module, axis_out_reg: a one-deep valid/ready pipeline register for data+last, parameterised on payload width.
- The FSM, beat counter and pulse generation stay in axis_msg_framer.

Test Plan:
- Reset release, then cmd_len=3 with data 0xA1,0xA2,0xA3 and s_tvalid/m_tready held 1 -> m_* carries A1,A2,A3 on consecutive cycles; m_tlast only with A3; tx_done pulses once, one cycle later; busy falls after the last handshake.
- cmd_len=1, data 0x55 -> a single beat with m_tlast=1; state back in IDLE and cmd_ready=1 the cycle after input acceptance.
- cmd_len=4, m_tready low for 3 cycles during beat 2 -> m_tdata/m_tlast hold beat 2 stable, s_tready=0 during the stall, no beat lost or duplicated; m_tlast on beat 4 only.
- cmd_len=0 -> cmd accepted, zero_len pulses for 1 cycle, m_tvalid stays 0, tx_done stays 0.
- Back-to-back: cmd_len=2 (0x10,0x11) then cmd_len=2 (0x20,0x21) -> exactly two m_tlast pulses (on 0x11 and 0x21) and exactly one bubble cycle between messages.
- cmd_len=5, rst asserted after 2 output beats -> all outputs return to reset values asynchronously; a new cmd_len=2 after reset completes normally with m_tlast on beat 2.
